// File: rtl/si_pkg.sv
// si_pkg
//   Shared definitions for the frame scheduler slice: the scheduler state
//   encoding, the default requester count, the fixed requester slot numbers
//   and the vertical blanking budget that the per-task timeout has to fit in.
//   No ports; imported by the interface, the scheduler and its timer.
package si_pkg;

   // Scheduler sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_START = 2'd2,
      ST_WAIT  = 2'd3
   } sched_state_e;

   localparam int NREQ_DEFAULT = 4;

   // Requester slots, served in ascending order every frame
   localparam int REQ_PLAYER   = 0;
   localparam int REQ_INVADERS = 1;
   localparam int REQ_SHOTS    = 2;
   localparam int REQ_COLLIDE  = 3;

   // Pixel clocks available inside vertical blanking for all updates together
   localparam int BLANK_BUDGET = 23296;

endpackage

// File: rtl/frame_scheduler_if.sv
// frame_scheduler_if
//   Bundles the signals between the frame scheduler and the game-logic
//   update units plus the VGA vsync input.
//   Signals:
//     vsync       - active-low vsync from the VGA timing generator
//     enable      - requester enable mask, sampled at frame start
//     done        - completion pulse/level from each requester
//     err_clr     - clears the sticky error flags
//     start       - one-cycle start pulse, at most one bit high
//     busy        - update sequence in progress (renderers freeze sprites)
//     frame_cnt   - vsync falling edges since reset, wrapping
//     timeout_err - sticky per-requester timeout flags
//     overrun     - sticky flag, a frame began while still busy
//   Modports:
//     master - the scheduler side
//     slave  - the requester / environment side
interface frame_scheduler_if
   import si_pkg::*;
#(
   parameter int NREQ = NREQ_DEFAULT,
   parameter int FCW  = 16
);

   logic            vsync;
   logic [NREQ-1:0] enable;
   logic [NREQ-1:0] done;
   logic            err_clr;
   logic [NREQ-1:0] start;
   logic            busy;
   logic [FCW-1:0]  frame_cnt;
   logic [NREQ-1:0] timeout_err;
   logic            overrun;

   modport master (
      input  vsync, enable, done, err_clr,
      output start, busy, frame_cnt, timeout_err, overrun
   );

   modport slave (
      output vsync, enable, done, err_clr,
      input  start, busy, frame_cnt, timeout_err, overrun
   );

endinterface

// File: rtl/sched_timeout_timer.sv
// sched_timeout_timer
//   Counts the cycles the scheduler has spent waiting on one requester.
//   Ports:
//     clk      - pixel clock
//     clr      - synchronous active-high reset
//     clear    - restart the count at zero on the next edge
//     count_en - advance the count by one on the next edge
//     expired  - the count has reached TIMEOUT-1 (last allowed wait cycle)
module sched_timeout_timer
   import si_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic clr,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   // The count never runs past LAST, so it cannot wrap back to zero when
   // TIMEOUT is a power of two.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && !expired) begin
         count_d = count_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Runs the per-frame game-logic updates inside vertical blanking. On each
//   vsync falling edge it latches the enable mask and starts every enabled
//   requester in slot order, waiting for each one's done (or a timeout)
//   before moving on. busy stays high for the whole sequence so renderers
//   can hold their sprite state stable.
//   Ports:
//     clk - pixel clock, same domain as the VGA timing generator
//     clr - synchronous active-high reset
//     bus - scheduler side of frame_scheduler_if (see the interface header)
module frame_scheduler
   import si_pkg::*;
#(
   parameter int NREQ    = NREQ_DEFAULT,
   parameter int TIMEOUT = 4096,
   parameter int FCW     = 16
) (
   input  logic                clk,
   input  logic                clr,
   frame_scheduler_if.master   bus
);

   localparam int IW = $clog2(NREQ + 1);
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   sched_state_e    state_q, state_d;
   logic            vsync_q, vsync_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [NREQ-1:0] mask_q, mask_d;
   logic [NREQ-1:0] start_q, start_d;
   logic            busy_q, busy_d;
   logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
   logic [NREQ-1:0] timeout_err_q, timeout_err_d;
   logic            overrun_q, overrun_d;

   logic            fall;
   logic [NREQ-1:0] cur_sel;
   logic            at_end;
   logic            done_cur;
   logic            timer_clear;
   logic            timer_count;
   logic            timer_expired;

   assign fall = vsync_q & ~bus.vsync;

   // One-hot select of the current slot; it is all zeros once idx reaches
   // NREQ, so it can be used to index mask/done without a range check.
   assign cur_sel  = ONE << idx_q;
   assign at_end   = (idx_q == IW'(NREQ));
   assign done_cur = |(bus.done & cur_sel);

   assign timer_clear = (state_q == ST_START);
   assign timer_count = (state_q == ST_WAIT) && !done_cur;

   sched_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .clr      (clr),
      .clear    (timer_clear),
      .count_en (timer_count),
      .expired  (timer_expired)
   );

   // Next-state logic. Sticky flags are cleared first and then re-set by
   // any error seen in the same cycle, so a coincident error survives
   // err_clr. A frame edge seen mid-sequence only counts and flags; the
   // running sequence carries on and nothing is queued.
   always_comb begin
      state_d       = state_q;
      vsync_d       = bus.vsync;
      idx_d         = idx_q;
      mask_d        = mask_q;
      frame_cnt_d   = frame_cnt_q;
      timeout_err_d = bus.err_clr ? '0 : timeout_err_q;
      overrun_d     = bus.err_clr ? 1'b0 : overrun_q;

      if (fall) begin
         frame_cnt_d = frame_cnt_q + FCW'(1);
         if (state_q != ST_IDLE) begin
            overrun_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               mask_d  = bus.enable;
               idx_d   = '0;
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (at_end) begin
               state_d = ST_IDLE;
            end else if (|(mask_q & cur_sel)) begin
               state_d = ST_START;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_cur) begin
               idx_d   = idx_q + IW'(1);
               state_d = ST_SCAN;
            end else if (timer_expired) begin
               timeout_err_d = timeout_err_d | cur_sel;
               idx_d         = idx_q + IW'(1);
               state_d       = ST_SCAN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      start_d = (state_d == ST_START) ? (ONE << idx_d) : '0;
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers; reset discards any frame edge sampled with it.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q       <= ST_IDLE;
         vsync_q       <= 1'b1;
         idx_q         <= '0;
         mask_q        <= '0;
         start_q       <= '0;
         busy_q        <= 1'b0;
         frame_cnt_q   <= '0;
         timeout_err_q <= '0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         vsync_q       <= vsync_d;
         idx_q         <= idx_d;
         mask_q        <= mask_d;
         start_q       <= start_d;
         busy_q        <= busy_d;
         frame_cnt_q   <= frame_cnt_d;
         timeout_err_q <= timeout_err_d;
         overrun_q     <= overrun_d;
      end
   end

   assign bus.start       = start_q;
   assign bus.busy        = busy_q;
   assign bus.frame_cnt   = frame_cnt_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler
//   Drives frames into frame_scheduler (TIMEOUT=16, FCW=4) and compares the
//   observed start times, busy length, flags and frame count against a
//   slot-by-slot timing model of the scheduling rules.
module tb_frame_scheduler;
   import si_pkg::*;

   localparam int NR = 4;
   localparam int TO = 16;
   localparam int FW = 4;

   logic clk = 1'b0;
   logic clr;

   frame_scheduler_if #(.NREQ(NR), .FCW(FW)) bus ();

   frame_scheduler #(
      .NREQ    (NR),
      .TIMEOUT (TO),
      .FCW     (FW)
   ) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int exp_frames = 0;

   int          obs_start_cyc [NR];
   int          obs_start_cnt [NR];
   int          obs_busy;
   int          starts_after_clr;
   int          exp_start_cyc [NR];
   int          exp_busy;
   logic [NR-1:0] exp_tmo;

   logic [NR-1:0] snap_start;
   logic          snap_busy;
   logic [FW-1:0] snap_cnt;
   logic [NR-1:0] snap_tmo;
   logic          snap_ovr;

   // Timing model. Cycle 0 is the cycle after the edge that sees vsync fall.
   // Each slot costs one SCAN cycle; an enabled slot adds a START cycle and
   // its WAIT cycles (answer at WAIT cycle k -> k+1 cycles, otherwise TO).
   // busy covers everything up to and including the final SCAN.
   function automatic void model_frame(input logic [NR-1:0] en, input int lat [NR]);
      int s;
      s = 0;
      exp_tmo = '0;
      for (int i = 0; i < NR; i++) begin
         exp_start_cyc[i] = -1;
         if (en[i]) begin
            exp_start_cyc[i] = s + 1;
            if (lat[i] >= 0 && lat[i] < TO) begin
               s = s + lat[i] + 3;
            end else begin
               s = s + TO + 2;
               exp_tmo[i] = 1'b1;
            end
         end else begin
            s = s + 1;
         end
      end
      exp_busy = s + 1;
   endfunction

   // Runs one frame: lat[i] is the WAIT cycle at which requester i answers
   // its start (-1 = never). Optional one-off events are given by cycle
   // number (-1 = none).
   task automatic run_frame(input logic [NR-1:0] en, input int lat [NR],
                            input int stray_slot, input int stray_cyc,
                            input int refall_cyc, input int errclr_cyc,
                            input int clr_cyc);
      int  cnt [NR];
      int  c;
      bit  fin;
      for (int i = 0; i < NR; i++) begin
         cnt[i] = 0;
         obs_start_cyc[i] = -1;
         obs_start_cnt[i] = 0;
      end
      obs_busy = 0;
      starts_after_clr = 0;
      bus.enable = en;
      @(negedge clk);
      bus.vsync = 1'b0;
      fin = 1'b0;
      c = 0;
      while (!fin) begin
         @(negedge clk);
         bus.done = '0;
         bus.err_clr = 1'b0;
         clr = 1'b0;
         if (c == 2) bus.vsync = 1'b1;
         if (refall_cyc >= 0 && c == refall_cyc) bus.vsync = 1'b0;
         if (refall_cyc >= 0 && c == refall_cyc + 2) bus.vsync = 1'b1;
         if (c == clr_cyc + 1) begin
            snap_start = bus.start;
            snap_busy  = bus.busy;
            snap_cnt   = bus.frame_cnt;
            snap_tmo   = bus.timeout_err;
            snap_ovr   = bus.overrun;
         end
         for (int i = 0; i < NR; i++) begin
            if (cnt[i] > 0) begin
               cnt[i] = cnt[i] - 1;
               if (cnt[i] == 0) bus.done[i] = 1'b1;
            end
         end
         for (int i = 0; i < NR; i++) begin
            if (bus.start[i]) begin
               obs_start_cnt[i]++;
               if (obs_start_cyc[i] < 0) obs_start_cyc[i] = c;
               if (clr_cyc >= 0 && c > clr_cyc) starts_after_clr++;
               if (lat[i] >= 0) cnt[i] = lat[i] + 1;
            end
         end
         if (stray_cyc == c) bus.done[stray_slot] = 1'b1;
         if (errclr_cyc == c) bus.err_clr = 1'b1;
         if (clr_cyc == c) clr = 1'b1;
         if (bus.busy) obs_busy++;
         if (c > 0 && !bus.busy && c > clr_cyc + 6 && c > refall_cyc + 3) begin
            fin = 1'b1;
         end else if (c > 400) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_bound: busy=%0b after %0d cycles, required 0", bus.busy, c);
            fin = 1'b1;
         end
         c++;
      end
      @(negedge clk);
      bus.done = '0;
      bus.err_clr = 1'b0;
      clr = 1'b0;
      bus.vsync = 1'b1;
   endtask

   task automatic pulse_err_clr();
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      bus.vsync = 1'b1;
      bus.enable = '0;
      bus.done = '0;
      bus.err_clr = 1'b0;
      repeat (3) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      exp_frames = 0;
      total++;
      if (bus.start !== 4'b0000) begin bad++; $display("[TB] FAIL reset_start: got %b, expected 0000", bus.start); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
      total++;
      if (bus.frame_cnt !== 4'd0) begin bad++; $display("[TB] FAIL reset_frame_cnt: got %0d, expected 0", bus.frame_cnt); end
      total++;
      if (bus.timeout_err !== 4'b0000) begin bad++; $display("[TB] FAIL reset_timeout_err: got %b, expected 0000", bus.timeout_err); end
      total++;
      if (bus.overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b, expected 0", bus.overrun); end
   endtask

   task automatic test_full_sequence();
      int lat [NR];
      lat = '{3, 3, 3, 3};
      model_frame(4'b1111, lat);
      run_frame(4'b1111, lat, 0, -1, -1, -1, -1);
      exp_frames++;
      for (int i = 0; i < NR; i++) begin
         total++;
         if (obs_start_cyc[i] !== exp_start_cyc[i] || obs_start_cnt[i] !== 1) begin
            bad++;
            $display("[TB] FAIL full_start%0d: got cycle %0d count %0d, expected cycle %0d count 1",
                     i, obs_start_cyc[i], obs_start_cnt[i], exp_start_cyc[i]);
         end
      end
      total++;
      if (obs_busy !== exp_busy) begin bad++; $display("[TB] FAIL full_busy_len: got %0d, expected %0d", obs_busy, exp_busy); end
      total++;
      if (bus.frame_cnt !== FW'(exp_frames)) begin bad++; $display("[TB] FAIL full_frame_cnt: got %0d, expected %0d", bus.frame_cnt, exp_frames % 16); end
      total++;
      if (bus.timeout_err !== 4'b0000 || bus.overrun !== 1'b0) begin
         bad++;
         $display("[TB] FAIL full_errors: got tmo=%b ovr=%b, expected 0000/0", bus.timeout_err, bus.overrun);
      end
   endtask

   task automatic test_skipped_slots();
      int lat [NR];
      lat = '{3, 3, 3, 3};
      model_frame(4'b0101, lat);
      // stray done[1] during WAIT cycle 0 of slot 0
      run_frame(4'b0101, lat, 1, 2, -1, -1, -1);
      exp_frames++;
      for (int i = 0; i < NR; i++) begin
         total++;
         if (obs_start_cyc[i] !== exp_start_cyc[i] || obs_start_cnt[i] !== (exp_start_cyc[i] >= 0 ? 1 : 0)) begin
            bad++;
            $display("[TB] FAIL skip_start%0d: got cycle %0d count %0d, expected cycle %0d",
                     i, obs_start_cyc[i], obs_start_cnt[i], exp_start_cyc[i]);
         end
      end
      total++;
      if (obs_busy !== exp_busy) begin bad++; $display("[TB] FAIL skip_busy_len: got %0d, expected %0d", obs_busy, exp_busy); end
      // done[0] raised during the START cycle must not end the slot early
      lat = '{5, 3, 3, 3};
      model_frame(4'b0001, lat);
      run_frame(4'b0001, lat, 0, 1, -1, -1, -1);
      exp_frames++;
      total++;
      if (obs_busy !== exp_busy) begin bad++; $display("[TB] FAIL start_cycle_done_busy: got %0d, expected %0d", obs_busy, exp_busy); end
   endtask

   task automatic test_timeout();
      int lat [NR];
      lat = '{3, -1, 3, 3};
      model_frame(4'b1111, lat);
      // err_clr lands in the cycle whose edge records the timeout
      run_frame(4'b1111, lat, 0, -1, -1, exp_start_cyc[1] + TO, -1);
      exp_frames++;
      total++;
      if (bus.timeout_err !== exp_tmo) begin bad++; $display("[TB] FAIL timeout_flag: got %b, expected %b", bus.timeout_err, exp_tmo); end
      total++;
      if (obs_start_cyc[2] !== exp_start_cyc[1] + TO + 2) begin
         bad++;
         $display("[TB] FAIL timeout_next_start: got %0d, expected %0d", obs_start_cyc[2], exp_start_cyc[1] + TO + 2);
      end
      total++;
      if (obs_busy !== exp_busy) begin bad++; $display("[TB] FAIL timeout_busy_len: got %0d, expected %0d", obs_busy, exp_busy); end
      pulse_err_clr();
      total++;
      if (bus.timeout_err !== 4'b0000) begin bad++; $display("[TB] FAIL timeout_clear: got %b, expected 0000", bus.timeout_err); end
   endtask

   task automatic test_overrun();
      int lat [NR];
      lat = '{10, 3, 3, 3};
      model_frame(4'b0001, lat);
      run_frame(4'b0001, lat, 0, -1, 4, -1, -1);
      exp_frames = exp_frames + 2;
      total++;
      if (bus.overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_flag: got %b, expected 1", bus.overrun); end
      total++;
      if (bus.frame_cnt !== FW'(exp_frames)) begin bad++; $display("[TB] FAIL overrun_frame_cnt: got %0d, expected %0d", bus.frame_cnt, exp_frames % 16); end
      total++;
      if (obs_start_cnt[0] !== 1 || obs_busy !== exp_busy) begin
         bad++;
         $display("[TB] FAIL overrun_single_start: got count %0d busy %0d, expected 1 and %0d", obs_start_cnt[0], obs_busy, exp_busy);
      end
      pulse_err_clr();
      total++;
      if (bus.overrun !== 1'b0) begin bad++; $display("[TB] FAIL overrun_clear: got %b, expected 0", bus.overrun); end
   endtask

   task automatic test_reset_mid();
      int lat [NR];
      lat = '{3, -1, 3, 3};
      model_frame(4'b1111, lat);
      // clr during WAIT cycle 1 of slot 2, with a timeout flag already set
      run_frame(4'b1111, lat, 0, -1, -1, -1, exp_start_cyc[2] + 2);
      exp_frames = 0;
      total++;
      if (snap_start !== 4'b0000 || snap_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_start_busy: got start=%b busy=%b, expected 0000/0", snap_start, snap_busy);
      end
      total++;
      if (snap_cnt !== 4'd0 || snap_tmo !== 4'b0000 || snap_ovr !== 1'b0) begin
         bad++;
         $display("[TB] FAIL midreset_regs: got cnt=%0d tmo=%b ovr=%b, expected 0/0000/0", snap_cnt, snap_tmo, snap_ovr);
      end
      total++;
      if (starts_after_clr !== 0 || obs_start_cnt[3] !== 0) begin
         bad++;
         $display("[TB] FAIL midreset_no_start: got %0d later starts, expected 0", starts_after_clr + obs_start_cnt[3]);
      end
   endtask

   task automatic test_wrap();
      int lat [NR];
      lat = '{0, 0, 0, 0};
      for (int f = 0; f < 15; f++) begin
         run_frame(4'b0000, lat, 0, -1, -1, -1, -1);
         exp_frames++;
      end
      total++;
      if (bus.frame_cnt !== FW'(exp_frames)) begin bad++; $display("[TB] FAIL wrap_before: got %0d, expected %0d", bus.frame_cnt, exp_frames % 16); end
      run_frame(4'b0000, lat, 0, -1, -1, -1, -1);
      exp_frames++;
      total++;
      if (bus.frame_cnt !== FW'(exp_frames)) begin bad++; $display("[TB] FAIL wrap_after: got %0d, expected %0d", bus.frame_cnt, exp_frames % 16); end
   endtask

   task automatic test_random();
      int          lat [NR];
      logic [NR-1:0] en;
      for (int f = 0; f < 10; f++) begin
         en = NR'($urandom_range(0, 15));
         for (int i = 0; i < NR; i++) lat[i] = int'($urandom_range(0, 20));
         pulse_err_clr();
         model_frame(en, lat);
         run_frame(en, lat, 0, -1, -1, -1, -1);
         exp_frames++;
         for (int i = 0; i < NR; i++) begin
            total++;
            if (obs_start_cyc[i] !== exp_start_cyc[i] || obs_start_cnt[i] !== (en[i] ? 1 : 0)) begin
               bad++;
               $display("[TB] FAIL rand%0d_start%0d: got cycle %0d count %0d, expected cycle %0d",
                        f, i, obs_start_cyc[i], obs_start_cnt[i], exp_start_cyc[i]);
            end
         end
         total++;
         if (obs_busy !== exp_busy) begin bad++; $display("[TB] FAIL rand%0d_busy: got %0d, expected %0d", f, obs_busy, exp_busy); end
         total++;
         if (bus.timeout_err !== exp_tmo) begin bad++; $display("[TB] FAIL rand%0d_tmo: got %b, expected %b", f, bus.timeout_err, exp_tmo); end
         total++;
         if (bus.frame_cnt !== FW'(exp_frames) || bus.overrun !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rand%0d_cnt_ovr: got cnt=%0d ovr=%b, expected %0d/0", f, bus.frame_cnt, bus.overrun, exp_frames % 16);
         end
      end
   endtask

   initial begin
      $display("[TB] frame_scheduler bench start");
      test_reset();
      test_full_sequence();
      test_skipped_slots();
      test_timeout();
      test_overrun();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
